// File: rtl/decoder_stream_pkg.sv
// Shared types and helpers for the one-hot decoder stream.
// Latency: n/a (declarations only). Backpressure: n/a.
package decoder_pkg;

    localparam int IN_W_DEFAULT = 2;
    localparam int IDX_MAX_W    = 5;
    localparam int OUT_MAX_W    = 2**IDX_MAX_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    // Callers cast the result down to their own one-hot width.
    function automatic logic [OUT_MAX_W-1:0] onehot_decode(
        input logic [IDX_MAX_W-1:0] index,
        input logic                 active
    );
        logic [OUT_MAX_W-1:0] vec;
        vec = '0;
        if (active) begin
            vec = OUT_MAX_W'(1) << index;
        end
        return vec;
    endfunction

endpackage

// File: rtl/decoder_stream_if.sv
// Handshake bundle between the decoder stream and its neighbours; the
// s_par/m_perr pair exists only when DECODER_STREAM_PARITY_EN is defined.
// Latency/backpressure: n/a (wires only).
interface decoder_stream_if #(
    parameter int IN_W = 2
);
    localparam int OUT_W = 2**IN_W;

    logic             s_valid;
    logic             s_ready;
    logic [IN_W-1:0]  s_y;
    logic             s_active;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_a;
    logic             m_active;
`ifdef DECODER_STREAM_PARITY_EN
    logic             s_par;
    logic             m_perr;

    modport slave (
        input  s_valid, s_y, s_active, s_par, m_ready,
        output s_ready, m_valid, m_a, m_active, m_perr
    );
    modport master (
        output s_valid, s_y, s_active, s_par, m_ready,
        input  s_ready, m_valid, m_a, m_active, m_perr
    );
`else
    modport slave (
        input  s_valid, s_y, s_active, m_ready,
        output s_ready, m_valid, m_a, m_active
    );
    modport master (
        output s_valid, s_y, s_active, m_ready,
        input  s_ready, m_valid, m_a, m_active
    );
`endif

endinterface

// File: rtl/decoder_stream_skid_buffer2.sv
// Generic 2-entry valid/ready skid buffer, strict FIFO order.
// Latency: 1 cycle when empty. Backpressure: in_rdy_o drops only when both
// entries are held; it is a function of registered state and reset only.
module skid_buffer2
    import decoder_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic [W-1:0] in_dat_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_dat_o
);

    buf_state_t   state_q;
    logic         vld_q;
    logic         rdy_q;
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic         accept;
    logic         deliver;

    assign in_rdy_o  = rdy_q & rst_ni;
    assign out_vld_o = vld_q;
    assign out_dat_o = head_q;
    assign accept    = in_vld_i & in_rdy_o;
    assign deliver   = vld_q & out_rdy_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_q  <= in_dat_i;
                        state_q <= ONE;
                        vld_q   <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !deliver) begin
                        tail_q  <= in_dat_i;
                        state_q <= FULL;
                        rdy_q   <= 1'b0;
                    end else if (deliver && !accept) begin
                        state_q <= EMPTY;
                        vld_q   <= 1'b0;
                    end else if (accept && deliver) begin
                        head_q  <= in_dat_i;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        head_q  <= tail_q;
                        state_q <= ONE;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    vld_q   <= 1'b0;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/decoder_stream.sv
// Streaming index -> one-hot decoder feeding a 2-entry skid buffer; optional
// parity check under DECODER_STREAM_PARITY_EN. Latency: 1 cycle when empty.
// Backpressure: s_ready falls only when both entries are held, low in reset.
module decoder_stream
    import decoder_pkg::*;
#(
    parameter int IN_W = IN_W_DEFAULT
) (
    input  logic             clock,
    input  logic             n_reset,
    decoder_stream_if.slave  bus
);

    localparam int OUT_W = 2**IN_W;

`ifdef DECODER_STREAM_PARITY_EN
    typedef struct packed {
        logic             perr;
        logic             active;
        logic [OUT_W-1:0] a;
    } entry_t;
`else
    typedef struct packed {
        logic             active;
        logic [OUT_W-1:0] a;
    } entry_t;
`endif

    entry_t in_ent;
    entry_t out_ent;

    always_comb begin
        in_ent        = '0;
        in_ent.active = bus.s_active;
        in_ent.a      = OUT_W'(onehot_decode(IDX_MAX_W'(bus.s_y), bus.s_active));
`ifdef DECODER_STREAM_PARITY_EN
        // Odd parity: {s_par, s_active, s_y} must carry an odd number of ones.
        if (!(^{bus.s_par, bus.s_active, bus.s_y})) begin
            in_ent.perr   = 1'b1;
            in_ent.active = 1'b0;
            in_ent.a      = '0;
        end
`endif
    end

    skid_buffer2 #(
        .W($bits(entry_t))
    ) u_buf (
        .clk_i     (clock),
        .rst_ni    (n_reset),
        .in_vld_i  (bus.s_valid),
        .in_rdy_o  (bus.s_ready),
        .in_dat_i  (in_ent),
        .out_vld_o (bus.m_valid),
        .out_rdy_i (bus.m_ready),
        .out_dat_o (out_ent)
    );

    assign bus.m_a      = out_ent.a;
    assign bus.m_active = out_ent.active;
`ifdef DECODER_STREAM_PARITY_EN
    assign bus.m_perr   = out_ent.perr;
`endif

endmodule
